// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes and FSM state encoding shared by alu_exec (ALU_MUL_EN)
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier, low WIDTH bits, one step per clock (used under ALU_MUL_EN)
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic             running;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_step;

  // product/done describe the step being taken this cycle, so the caller can
  // register the final sum on the same edge as the last accumulation.
  assign acc_step = mplier[0] ? acc + mcand : acc;
  assign product  = acc_step;
  assign done     = running && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      mcand   <= a;
      mplier  <= b;
      acc     <= '0;
    end else if (running) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - registered ALU execution unit; ALU_MUL_EN adds the multicycle MUL path
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [2:0]       AluCtl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] AluOut,
  output logic             Zero,
  output logic             Busy,
  output logic             Done
);

  logic [WIDTH-1:0] alu_res;

  // Reserved codes, and MUL when the multiplier is absent, fall to the default of 0.
  always_comb begin
    alu_res = '0;
    case (AluCtl)
      ALU_AND: alu_res = SrcA & SrcB;
      ALU_OR:  alu_res = SrcA | SrcB;
      ALU_ADD: alu_res = SrcA + SrcB;
      ALU_SUB: alu_res = SrcA - SrcB;
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  alu_state_t       state;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  assign mul_start = (state == IDLE) && Start && (AluCtl == ALU_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (SrcA),
    .b       (SrcB),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      AluOut <= '0;
      Zero   <= 1'b1;
      Busy   <= 1'b0;
      Done   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (AluCtl == ALU_MUL) begin
              Busy  <= 1'b1;
              state <= MUL;
            end else begin
              AluOut <= alu_res;
              Zero   <= (alu_res == '0);
              Done   <= 1'b1;
            end
          end
        end
        MUL: begin
          if (mul_done) begin
            AluOut <= mul_prod;
            Zero   <= (mul_prod == '0);
            Done   <= 1'b1;
            Busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign Busy = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      AluOut <= '0;
      Zero   <= 1'b1;
      Done   <= 1'b0;
    end else begin
      Done <= 1'b0;
      if (Start) begin
        AluOut <= alu_res;
        Zero   <= (alu_res == '0);
        Done   <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - directed self-checking bench for alu_exec, both ALU_MUL_EN builds
module tb_alu_exec;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        Start = 1'b0;
  logic [2:0]  AluCtl = 3'b000;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic [31:0] AluOut;
  logic        Zero;
  logic        Busy;
  logic        Done;

  int errors = 0;
  int checks = 0;

  alu_exec #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .Start  (Start),
    .AluCtl (AluCtl),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .AluOut (AluOut),
    .Zero   (Zero),
    .Busy   (Busy),
    .Done   (Done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request for exactly one edge; returns #1 after that edge (result cycle).
  task automatic issue(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    Start  = 1'b1;
    AluCtl = ctl;
    SrcA   = a;
    SrcB   = b;
    @(posedge clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic single(input string tag, input logic [2:0] ctl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    issue(ctl, a, b);
    check({tag, "_out"}, AluOut, exp);
    check({tag, "_zero"}, {31'b0, Zero}, {31'b0, exp == 32'h0});
    check({tag, "_done"}, {31'b0, Done}, 32'h1);
    check({tag, "_busy"}, {31'b0, Busy}, 32'h0);
  endtask

`ifdef ALU_MUL_EN
  // Issues MUL, spams ignored ADD requests while busy, counts Busy/Done cycles.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input logic [31:0] prev);
    int busy_n = 0;
    int done_n = 0;
    int done_at = 0;
    logic [31:0] res = '0;
    issue(ALU_MUL, a, b);
    for (int i = 1; i <= 40; i++) begin
      if (Busy) busy_n++;
      if (Done) begin
        done_n++;
        if (done_at == 0) done_at = i;
        res = AluOut;
      end
      if (i == 5) check({tag, "_hold"}, AluOut, prev);
      @(negedge clk);
      Start  = (i < 20);
      AluCtl = ALU_ADD;
      SrcA   = 32'h1;
      SrcB   = 32'h1;
      @(posedge clk);
      #1;
    end
    Start = 1'b0;
    check({tag, "_busy_cycles"}, busy_n, 32);
    check({tag, "_done_count"}, done_n, 1);
    check({tag, "_done_at"}, done_at, 33);
    check({tag, "_result"}, res, exp);
    check({tag, "_zero"}, {31'b0, Zero}, {31'b0, exp == 32'h0});
  endtask
`endif

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", AluOut, 32'h0);
    check("rst_zero", {31'b0, Zero}, 32'h1);
    check("rst_busy", {31'b0, Busy}, 32'h0);
    check("rst_done", {31'b0, Done}, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    single("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'h1, 32'h0);
    @(posedge clk);
    #1;
    check("idle_done", {31'b0, Done}, 32'h0);
    check("idle_hold", AluOut, 32'h0);

    single("sub", ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
    single("slt_neg", ALU_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1);
    single("slt_pos", ALU_SLT, 32'h1, 32'hFFFF_FFFF, 32'h0);
    single("and", ALU_AND, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0);
    single("or", ALU_OR, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0);
    single("add", ALU_ADD, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789);
    single("rsv100", 3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    single("slt_eq", ALU_SLT, 32'h8000_0000, 32'h8000_0000, 32'h0);
    // back-to-back: second request on the very next edge
    single("b2b_a", ALU_OR, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003);
    single("b2b_b", ALU_ADD, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007);

`ifdef ALU_MUL_EN
    run_mul("mul", 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 32'h0000_0007);
    run_mul("mul_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0005_000F);
    run_mul("mul_zero", 32'h1234_5678, 32'h0, 32'h0, 32'h0000_0001);

    issue(ALU_MUL, 32'd6, 32'd7);
    for (int i = 0; i < 40; i++) begin
      if (Done) break;
      @(posedge clk);
      #1;
    end
    check("mul_b2b_done", {31'b0, Done}, 32'h1);
    check("mul_b2b_res", AluOut, 32'd42);
    single("mul_b2b_next", ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);

    issue(ALU_MUL, 32'd7, 32'd9);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    check("abort_busy_pre", {31'b0, Busy}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_out", AluOut, 32'h0);
    check("abort_zero", {31'b0, Zero}, 32'h1);
    check("abort_busy", {31'b0, Busy}, 32'h0);
    check("abort_done", {31'b0, Done}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    begin
      int stray = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk);
        #1;
        if (Done || Busy) stray++;
      end
      check("abort_no_done", stray, 0);
    end
    single("post_abort_and", ALU_AND, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0);
`else
    single("mul_off", ALU_MUL, 32'h0001_0003, 32'h0000_0005, 32'h0);
    single("pre_rst", ALU_ADD, 32'h10, 32'h20, 32'h30);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_rst_out", AluOut, 32'h0);
    check("async_rst_zero", {31'b0, Zero}, 32'h1);
    @(negedge clk);
    reset = 1'b0;
    single("post_rst_and", ALU_AND, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
